// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, PC alignment mask and
// the default instruction width (also used by the decode hazard logic).
`timescale 1ns/1ps
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam int unsigned ALIGN_MASK    = 3;
  localparam int unsigned DEF_INST_BITS = 32;

endpackage

// File: rtl/fetch_perf_cnt.sv
// 16-bit saturating event counter with synchronous clear; used for fetch statistics.
`timescale 1ns/1ps
module fetch_perf_cnt (
  input  logic        clock,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 16'h0000;
    end else if (inc && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge clock) begin
    cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one memory request per PC, redirect/drain handling, decode stall hold.
// Optional FETCH_PERF_EN adds saturating fetch/flush/stall event counters.
`timescale 1ns/1ps
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDRESS_BITS = 16,
  parameter int INST_BITS    = DEF_INST_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_BITS-1:0] pc_in,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_BITS-1:0] redirect_target,
  input  logic                    stall,
  input  logic                    mem_ack,
  input  logic [INST_BITS-1:0]    mem_rdata,
  output logic                    mem_req,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic                    pc_advance,
  output logic                    next_PC_select,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic                    inst_valid,
  output logic [INST_BITS-1:0]    inst_out,
`ifdef FETCH_PERF_EN
  output logic [15:0]             perf_fetch_cnt,
  output logic [15:0]             perf_flush_cnt,
  output logic [15:0]             perf_stall_cnt,
`endif
  output logic [ADDRESS_BITS-1:0] inst_pc
);

  localparam logic [ADDRESS_BITS-1:0] LOW_MASK = ADDRESS_BITS'(ALIGN_MASK);

  fetch_state_e            state_q, state_d;
  logic                    mem_req_q, mem_req_d;
  logic [ADDRESS_BITS-1:0] mem_addr_q, mem_addr_d;
  logic                    inst_valid_q, inst_valid_d;
  logic [INST_BITS-1:0]    inst_out_q, inst_out_d;
  logic [ADDRESS_BITS-1:0] inst_pc_q, inst_pc_d;
  logic [ADDRESS_BITS-1:0] target_aligned;
  logic                    accept;

  assign target_aligned = redirect_target & ~LOW_MASK;
  assign accept         = (state_q == REQ) && mem_ack && !redirect_valid;

  always_comb begin
    state_d        = state_q;
    mem_addr_d     = mem_addr_q;
    inst_valid_d   = inst_valid_q;
    inst_out_d     = inst_out_q;
    inst_pc_d      = inst_pc_q;
    pc_advance     = 1'b0;
    next_PC_select = 1'b0;
    target_PC      = '0;

    if (redirect_valid) begin
      pc_advance     = 1'b1;
      next_PC_select = 1'b1;
      target_PC      = target_aligned;
      inst_valid_d   = 1'b0;
      // Without an ack the old request is still in flight and must be drained first.
      if ((state_q == REQ || state_q == DRAIN) && !mem_ack) begin
        state_d = DRAIN;
      end else begin
        mem_addr_d = target_aligned;
        state_d    = REQ;
      end
    end else begin
      case (state_q)
        IDLE: begin
          mem_addr_d = pc_in;
          state_d    = REQ;
        end
        REQ: begin
          if (mem_ack) begin
            inst_out_d   = mem_rdata;
            inst_pc_d    = mem_addr_q;
            inst_valid_d = 1'b1;
            pc_advance   = 1'b1;
            state_d      = HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            inst_valid_d = 1'b0;
            mem_addr_d   = pc_in;
            state_d      = REQ;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            mem_addr_d = pc_in;
            state_d    = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    mem_req_d = (state_d == REQ) || (state_d == DRAIN);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;

`ifdef FETCH_PERF_EN
  fetch_perf_cnt u_fetch_cnt (
    .clock (clock),
    .clear (!reset),
    .inc   (accept),
    .count (perf_fetch_cnt)
  );

  fetch_perf_cnt u_flush_cnt (
    .clock (clock),
    .clear (!reset),
    .inc   (redirect_valid),
    .count (perf_flush_cnt)
  );

  fetch_perf_cnt u_stall_cnt (
    .clock (clock),
    .clear (!reset),
    .inc   ((state_q == HOLD) && stall),
    .count (perf_stall_cnt)
  );
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed reset/stall/redirect/drain cases plus a short random
// fetch run; accepted instructions go through an expected-result queue.
`timescale 1ns/1ps
module tb_fetch_ctrl;

  localparam int AB = 16;
  localparam int IB = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [AB-1:0] pc_in;
  logic          redirect_valid;
  logic [AB-1:0] redirect_target;
  logic          stall;
  logic          mem_ack;
  logic [IB-1:0] mem_rdata;
  logic          mem_req;
  logic [AB-1:0] mem_addr;
  logic          pc_advance;
  logic          next_PC_select;
  logic [AB-1:0] target_PC;
  logic          inst_valid;
  logic [IB-1:0] inst_out;
  logic [AB-1:0] inst_pc;
`ifdef FETCH_PERF_EN
  logic [15:0]   perf_fetch_cnt;
  logic [15:0]   perf_flush_cnt;
  logic [15:0]   perf_stall_cnt;
`endif

  always #5 clock = ~clock;

  fetch_ctrl #(.ADDRESS_BITS(AB), .INST_BITS(IB)) dut (
    .clock           (clock),
    .reset           (reset),
    .pc_in           (pc_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .pc_advance      (pc_advance),
    .next_PC_select  (next_PC_select),
    .target_PC       (target_PC),
    .inst_valid      (inst_valid),
    .inst_out        (inst_out),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_stall_cnt  (perf_stall_cnt),
`endif
    .inst_pc         (inst_pc)
  );

  // Fetch-unit PC register driven by the sequencer's advance/select outputs.
  logic [AB-1:0] pc_q;
  always @(posedge clock) begin
    if (!reset) pc_q <= '0;
    else if (pc_advance) pc_q <= next_PC_select ? target_PC : pc_q + 16'd4;
  end
  assign pc_in = pc_q;

  typedef struct packed {
    logic [AB-1:0] pc;
    logic [IB-1:0] inst;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stall_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_inst(input string tag);
    exp_t e;
    check({tag, "_valid"}, 32'(inst_valid), 32'd1);
    check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_inst"}, inst_out, e.inst);
      check({tag, "_pc"}, 32'(inst_pc), 32'(e.pc));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AB-1:0] exp_pc;
    logic [IB-1:0] rd;
    int            n;

    reset = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    stall = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

    // 1: reset held two cycles
    step(); step();
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst_out, 32'd0);
    check("rst_ipc", 32'(inst_pc), 32'd0);
    check("rst_adv", 32'(pc_advance), 32'd0);
    reset = 1'b1;
    step();
    check("t1_req", 32'(mem_req), 32'd1);
    check("t1_addr", 32'(mem_addr), 32'h0000);

    // 2: ack after two wait cycles
    step(); step();
    check("t2_wait_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h00500093;
    #1;
    check("t2_adv", 32'(pc_advance), 32'd1);
    check("t2_sel", 32'(next_PC_select), 32'd0);
    sb.push_back('{pc: 16'h0000, inst: 32'h00500093});
    step();
    mem_ack = 1'b0; stall = 1'b1;
    #1;
    check_inst("t2");
    check("t2_adv_off", 32'(pc_advance), 32'd0);
    check("t2_req_off", 32'(mem_req), 32'd0);

    // 3: three stalled cycles in HOLD, stray ack ignored
    step(); stall_total += 1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step(); stall_total += 1;
    mem_ack = 1'b0;
    check("t3_inst", inst_out, 32'h00500093);
    check("t3_valid", 32'(inst_valid), 32'd1);
    check("t3_req", 32'(mem_req), 32'd0);
    step(); stall_total += 1;
    stall = 1'b0;
    step();
    check("t3_req_next", 32'(mem_req), 32'd1);
    check("t3_addr_next", 32'(mem_addr), 32'h0004);
    check("t3_valid_off", 32'(inst_valid), 32'd0);

    // 4: redirect while request pending -> drain
    redirect_valid = 1'b1; redirect_target = 16'h0010;
    #1;
    check("t4_sel", 32'(next_PC_select), 32'd1);
    check("t4_tgt", 32'(target_PC), 32'h0010);
    check("t4_adv", 32'(pc_advance), 32'd1);
    step();
    redirect_valid = 1'b0; redirect_target = '0;
    check("t4_drain_req", 32'(mem_req), 32'd1);
    check("t4_drain_addr", 32'(mem_addr), 32'h0004);
    step();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0;
    check("t4_valid", 32'(inst_valid), 32'd0);
    check("t4_addr", 32'(mem_addr), 32'h0010);
    check("t4_req", 32'(mem_req), 32'd1);

    // 5: redirect with ack in the same cycle, unaligned target
    step();
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    redirect_valid = 1'b1; redirect_target = 16'h0013;
    #1;
    check("t5_tgt", 32'(target_PC), 32'h0010);
    check("t5_sel", 32'(next_PC_select), 32'd1);
    step();
    mem_ack = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    check("t5_valid", 32'(inst_valid), 32'd0);
    check("t5_addr", 32'(mem_addr), 32'h0010);
    check("t5_req", 32'(mem_req), 32'd1);

    // plain fetch at the redirect target, consumed without stall
    mem_ack = 1'b1; mem_rdata = 32'h00A00113;
    sb.push_back('{pc: 16'h0010, inst: 32'h00A00113});
    step();
    mem_ack = 1'b0;
    check_inst("f10");
    step();
    check("f10_next_addr", 32'(mem_addr), 32'h0014);

    // random ack latency and stall lengths
    exp_pc = 16'h0014;
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(0, 3);
      repeat (n) step();
      check("rnd_addr", 32'(mem_addr), 32'(exp_pc));
      rd = $urandom;
      mem_ack = 1'b1; mem_rdata = rd;
      sb.push_back('{pc: exp_pc, inst: rd});
      step();
      mem_ack = 1'b0;
      n = $urandom_range(0, 2);
      stall = (n > 0);
      check_inst("rnd");
      repeat (n) step();
      stall_total += n;
      stall = 1'b0;
      step();
      exp_pc = exp_pc + 16'd4;
      check("rnd_next_addr", 32'(mem_addr), 32'(exp_pc));
      check("rnd_valid_off", 32'(inst_valid), 32'd0);
    end

    // 6: reset during DRAIN with a coincident ack
    redirect_valid = 1'b1; redirect_target = 16'h0100;
    step();
    redirect_valid = 1'b0; redirect_target = '0;
    check("t6_drain_req", 32'(mem_req), 32'd1);
`ifdef FETCH_PERF_EN
    check("perf_fetch", 32'(perf_fetch_cnt), 32'd10);
    check("perf_flush", 32'(perf_flush_cnt), 32'd3);
    check("perf_stall", 32'(perf_stall_cnt), 32'(stall_total));
`endif
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    check("t6_req", 32'(mem_req), 32'd0);
    check("t6_valid", 32'(inst_valid), 32'd0);
    check("t6_addr", 32'(mem_addr), 32'd0);
    check("t6_inst", inst_out, 32'd0);
`ifdef FETCH_PERF_EN
    check("t6_perf_fetch", 32'(perf_fetch_cnt), 32'd0);
    check("t6_perf_flush", 32'(perf_flush_cnt), 32'd0);
    check("t6_perf_stall", 32'(perf_stall_cnt), 32'd0);
`endif
    reset = 1'b1;
    step();
    check("t6_restart_req", 32'(mem_req), 32'd1);
    check("t6_restart_addr", 32'(mem_addr), 32'h0000);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
